cam_tcam_bank: RTL and testbench
================================

# cam_tcam_bank

Parametrised content-addressable memory bank for the Pass-Keeper key store. Keys wider than one RAM address are split into fixed-width chunks and stored transposed: one one-hot-per-entry bit row per (chunk index, chunk value). Search, write and erase are multi-cycle commands over a valid/ready command channel and a held response channel. An automatic post-reset sweep guarantees the RAM holds no stale match bits.

## Interface
- KEY_WIDTH, 16: key width in bits; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 4: bits per chunk; each chunk indexes 2^CHUNK_WIDTH rows.
- ENTRIES, 8: number of CAM entries (row width), at least 2.
- Derived: N = KEY_WIDTH/CHUNK_WIDTH; ADDR_WIDTH = clog2(ENTRIES); ROWS = N*2^CHUNK_WIDTH.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bank accepts a command this cycle.
- cmd_op  in  2  00 search, 01 write, 10 erase, 11 reserved (no-op).
- cmd_addr  in  ADDR_WIDTH  entry for write/erase; ignored for search.
- cmd_key  in  KEY_WIDTH  key for write/search; ignored for erase.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_hit  out  1  search: any match; write/erase: operation took effect.
- rsp_addr  out  ADDR_WIDTH  search: lowest matching index; write/erase: cmd_addr.
- rsp_match_vec  out  ENTRIES  search: all matching entries; else 0.
- entry_valid  out  ENTRIES  per-entry valid flags.

## Operation
- Storage: one RAM of ROWS x ENTRIES bits, row address {chunk_idx, chunk_val}, per-bit write enable, synchronous 1-cycle read; shadow key array ENTRIES x KEY_WIDTH (not reset); entry_valid register.
- Bit value 1 = entry holds that chunk value.
- States: INIT, IDLE, CLEAR, SET, SEARCH, RESP.
- INIT: entered on reset; writes all-zero to rows 0..ROWS-1, one per cycle; then IDLE.
- IDLE: cmd_ready=1; handshake (cmd_valid&&cmd_ready) latches op/addr/key.
- Search: SEARCH reads row {k, key chunk k} for k=0..N-1, one per cycle; accumulator starts at entry_valid and is ANDed with each returned row; then RESP with rsp_match_vec=accumulator, rsp_hit=|accumulator, rsp_addr=lowest set index (0 if none).
- Write: if entry valid, CLEAR clears bit cmd_addr in row {k, shadow chunk k} for k=0..N-1; then SET sets bit cmd_addr in row {k, new chunk k}; shadow key updated, entry_valid[addr]=1; RESP rsp_hit=1.
- Erase: valid entry -> CLEAR pass, entry_valid[addr]=0, rsp_hit=1; invalid entry -> straight to RESP, rsp_hit=0.
- Reserved op: straight to RESP, rsp_hit=0, rsp_addr=cmd_addr.
- Duplicate keys are legal; search reports all in rsp_match_vec, lowest in rsp_addr.
- Chunk index counter is clog2(N) bits (min 1), resets to 0 on entering each multi-cycle state.

## Timing
- Reset values: cmd_ready=0, rsp_valid=0, rsp_hit=0, rsp_addr=0, rsp_match_vec=0, entry_valid=0, state=INIT.
- INIT lasts ROWS cycles after rst_n deasserts; cmd_ready first rises at edge ROWS (64 with defaults).
- Handshake at edge E0: search rsp_valid at E0+N+1; write to invalid entry E0+N+1; write to valid entry E0+2N+1; erase valid E0+N+1; erase invalid or reserved E0+1.
- cmd_ready=0 from E0 until the cycle after rsp_valid&&rsp_ready; response outputs stable while rsp_valid&&!rsp_ready.
- rsp_valid&&rsp_ready at edge E1 -> rsp_valid=0 and cmd_ready=1 after E1; no back-to-back acceptance in that same cycle.
- rst_n low mid-command: command abandoned, no response, entry_valid cleared, INIT rerun in full.

## Test plan
- Reset then idle -> cmd_ready low exactly 64 cycles, all outputs 0, search key 0x0000 returns hit=0, match_vec=0x00.
- Write 0xBEEF to entry 3, search 0xBEEF -> write response E0+5 hit=1 addr=3; search E0+5 hit=1 addr=3 match_vec=0x08; search 0xBEEE -> hit=0.
- Overwrite entry 3 with 0x1234 -> response at E0+9; search 0xBEEF hit=0; search 0x1234 match_vec=0x08.
- Write 0x5A5A to entries 6 and 2, search -> match_vec=0x44, addr=2; erase 2 -> hit=1; search -> match_vec=0x40, addr=6; erase 2 again -> hit=0 at E0+1.
- Hold rsp_ready=0 for 10 cycles after search -> outputs stable, cmd_ready=0 throughout; reserved op 11 -> hit=0 at E0+1.
- Assert rst_n low during SET of write 0xCAFE to entry 1 -> no response, entry_valid=0, INIT 64 cycles; search 0xCAFE -> hit=0.

Source files
------------

// File: rtl/cam_tcam_bank.sv
// ============================================================================
// Module      : cam_tcam_bank
// Description : Transposed-RAM CAM bank; keys split into chunks, one
//               per-entry bit row per (chunk index, chunk value).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_tcam_bank #(
  parameter int KEY_WIDTH   = 16,
  parameter int CHUNK_WIDTH = 4,
  parameter int ENTRIES     = 8,
  parameter int ADDR_WIDTH  = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [KEY_WIDTH-1:0]  cmd_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ENTRIES-1:0]    rsp_match_vec,
  output logic [ENTRIES-1:0]    entry_valid
);

  localparam int c_chunks = KEY_WIDTH / CHUNK_WIDTH;
  localparam int c_rows   = c_chunks * (1 << CHUNK_WIDTH);
  localparam int c_idx_w  = (c_chunks > 1) ? $clog2(c_chunks) : 1;
  localparam int c_raw    = c_idx_w + CHUNK_WIDTH;
  localparam logic [c_raw-1:0]   c_last_row = c_raw'(c_rows - 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_chunks - 1);

  localparam logic [1:0] c_op_search = 2'b00;
  localparam logic [1:0] c_op_write  = 2'b01;
  localparam logic [1:0] c_op_erase  = 2'b10;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_SET    = 3'd3,
    ST_SEARCH = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  state_t                  r_state;
  logic [c_raw-1:0]        r_row;
  logic [c_idx_w-1:0]      r_idx;
  logic [1:0]              r_op;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [KEY_WIDTH-1:0]    r_key;
  logic                    r_took;
  logic [ENTRIES-1:0]      r_acc;
  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic                    r_rsp_hit;
  logic [ADDR_WIDTH-1:0]   r_rsp_addr;
  logic [ENTRIES-1:0]      r_rsp_match;
  logic [ENTRIES-1:0]      r_entry_valid;

  logic [ENTRIES-1:0]      r_mem [c_rows];
  logic [ENTRIES-1:0]      r_rd_data;
  logic [KEY_WIDTH-1:0]    r_shadow [ENTRIES];

  logic [CHUNK_WIDTH-1:0]  w_key_chunks [c_chunks];
  logic [CHUNK_WIDTH-1:0]  w_old_chunks [c_chunks];
  logic [KEY_WIDTH-1:0]    w_old_key;
  logic [c_raw-1:0]        w_rd_row;
  logic [c_raw-1:0]        w_wr_row;
  logic                    w_we;
  logic [ENTRIES-1:0]      w_wbe;
  logic [ENTRIES-1:0]      w_wdata;
  logic [ENTRIES-1:0]      w_onehot;
  logic [ENTRIES-1:0]      w_match;
  logic [ADDR_WIDTH-1:0]   w_lowest;
  logic                    w_set_done;

  assign w_old_key = r_shadow[r_addr];

  generate
    for (genvar g = 0; g < c_chunks; g++) begin : g_chunk
      assign w_key_chunks[g] = r_key[g*CHUNK_WIDTH +: CHUNK_WIDTH];
      assign w_old_chunks[g] = w_old_key[g*CHUNK_WIDTH +: CHUNK_WIDTH];
    end
  endgenerate

  assign w_onehot   = {{(ENTRIES-1){1'b0}}, 1'b1} << r_addr;
  assign w_rd_row   = {r_idx, w_key_chunks[r_idx]};
  assign w_match    = r_acc & r_rd_data;
  assign w_set_done = (r_state == ST_SET) && (r_idx == c_last_idx);

  always_comb begin
    w_we     = 1'b0;
    w_wr_row = '0;
    w_wbe    = '0;
    w_wdata  = '0;
    case (r_state)
      ST_INIT: begin
        w_we     = 1'b1;
        w_wr_row = r_row;
        w_wbe    = '1;
      end
      ST_CLEAR: begin
        w_we     = 1'b1;
        w_wr_row = {r_idx, w_old_chunks[r_idx]};
        w_wbe    = w_onehot;
      end
      ST_SET: begin
        w_we     = 1'b1;
        w_wr_row = {r_idx, w_key_chunks[r_idx]};
        w_wbe    = w_onehot;
        w_wdata  = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_lowest = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) w_lowest = ADDR_WIDTH'(i);
    end
  end

  // Bit-row RAM: synchronous read every cycle, per-bit write enable.
  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[w_rd_row];
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_we && w_wbe[i]) r_mem[w_wr_row][i] <= w_wdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_set_done) r_shadow[r_addr] <= r_key;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_row         <= '0;
      r_idx         <= '0;
      r_op          <= '0;
      r_addr        <= '0;
      r_key         <= '0;
      r_took        <= 1'b0;
      r_acc         <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_rsp_addr    <= '0;
      r_rsp_match   <= '0;
      r_entry_valid <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_row <= r_row + 1'b1;
          if (r_row == c_last_row) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_op        <= cmd_op;
            r_addr      <= cmd_addr;
            r_key       <= cmd_key;
            r_idx       <= '0;
            r_acc       <= r_entry_valid;
            r_took      <= 1'b0;
            case (cmd_op)
              c_op_search: r_state <= ST_SEARCH;
              c_op_write: begin
                r_took  <= 1'b1;
                r_state <= r_entry_valid[cmd_addr] ? ST_CLEAR : ST_SET;
              end
              c_op_erase: begin
                r_took  <= r_entry_valid[cmd_addr];
                r_state <= r_entry_valid[cmd_addr] ? ST_CLEAR : ST_RESP;
              end
              default: r_state <= ST_RESP;
            endcase
          end
        end
        ST_CLEAR: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == c_last_idx) begin
            r_idx <= '0;
            if (r_op == c_op_write) begin
              r_state <= ST_SET;
            end else begin
              r_entry_valid[r_addr] <= 1'b0;
              r_state               <= ST_RESP;
            end
          end
        end
        ST_SET: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == c_last_idx) begin
            r_idx                 <= '0;
            r_entry_valid[r_addr] <= 1'b1;
            r_state               <= ST_RESP;
          end
        end
        ST_SEARCH: begin
          // Read data lags the address by one cycle; the last row is folded in at RESP.
          r_idx <= r_idx + 1'b1;
          if (r_idx != '0) r_acc <= r_acc & r_rd_data;
          if (r_idx == c_last_idx) begin
            r_idx   <= '0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            if (r_op == c_op_search) begin
              r_rsp_match <= w_match;
              r_rsp_hit   <= |w_match;
              r_rsp_addr  <= w_lowest;
            end else begin
              r_rsp_match <= '0;
              r_rsp_hit   <= r_took;
              r_rsp_addr  <= r_addr;
            end
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_hit       = r_rsp_hit;
  assign rsp_addr      = r_rsp_addr;
  assign rsp_match_vec = r_rsp_match;
  assign entry_valid   = r_entry_valid;

endmodule

`default_nettype wire

// File: tb/tb_cam_tcam_bank.sv
// ============================================================================
// Module      : tb_cam_tcam_bank
// Description : Self-checking bench for cam_tcam_bank against a key-array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_tcam_bank;

  localparam int KW  = 16;
  localparam int NE  = 8;
  localparam int AW  = 3;
  localparam int NCH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [KW-1:0] cmd_key = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_hit;
  logic [AW-1:0] rsp_addr;
  logic [NE-1:0] rsp_match_vec;
  logic [NE-1:0] entry_valid;

  int checks = 0;
  int failures = 0;

  bit            m_valid [NE];
  logic [KW-1:0] m_key   [NE];

  cam_tcam_bank dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_match_vec(rsp_match_vec), .entry_valid(entry_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [NE-1:0] model_vec(input logic [KW-1:0] k);
    logic [NE-1:0] v = '0;
    for (int i = 0; i < NE; i++) if (m_valid[i] && m_key[i] == k) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NE-1:0] model_valid();
    logic [NE-1:0] v = '0;
    for (int i = 0; i < NE; i++) v[i] = m_valid[i];
    return v;
  endfunction

  // Expected {latency, hit, addr, match_vec} from the model's current contents.
  function automatic logic [19:0] model_rsp(input logic [1:0] op, input logic [AW-1:0] a,
                                            input logic [KW-1:0] k);
    logic [NE-1:0] v;
    logic [AW-1:0] lo = '0;
    case (op)
      2'b00: begin
        v = model_vec(k);
        for (int i = NE - 1; i >= 0; i--) if (v[i]) lo = AW'(i);
        return {8'(NCH + 1), |v, lo, v};
      end
      2'b01:   return {(m_valid[a] ? 8'(2*NCH + 1) : 8'(NCH + 1)), 1'b1, a, 8'h00};
      2'b10:   return {(m_valid[a] ? 8'(NCH + 1) : 8'd1), m_valid[a], a, 8'h00};
      default: return {8'd1, 1'b0, a, 8'h00};
    endcase
  endfunction

  function automatic void model_apply(input logic [1:0] op, input logic [AW-1:0] a,
                                      input logic [KW-1:0] k);
    if (op == 2'b01) begin
      m_valid[a] = 1'b1;
      m_key[a]   = k;
    end else if (op == 2'b10) begin
      m_valid[a] = 1'b0;
    end
  endfunction

  task automatic count_init(output int n);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  // Issue one command from a negedge; returns with the response held and unconsumed.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [KW-1:0] k, output int lat);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk); w++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL cmd_ready_wait got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_key = k;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_key = KW'($urandom);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    if (rsp_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL rsp_wait got=%b want=1", rsp_valid);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [KW-1:0] k, output logic [19:0] got);
    int lat;
    issue(op, a, k, lat);
    got = {8'(lat), rsp_hit, rsp_addr, rsp_match_vec};
    consume();
    model_apply(op, a, k);
  endtask

  task automatic test_reset();
    int n;
    logic [19:0] r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_match_vec, entry_valid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {cmd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_match_vec, entry_valid});
    end
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    rst_n = 1'b1;
    count_init(n);
    checks++;
    if (n !== 64) begin failures++; $display("FAIL init_cycles got=%0d want=64", n); end
    run_cmd(2'b00, 3'd0, 16'h0000, r);
    checks++;
    if (r !== {8'd5, 1'b0, 3'd0, 8'h00}) begin
      failures++; $display("FAIL search_empty got=%h want=%h", r, {8'd5, 1'b0, 3'd0, 8'h00});
    end
  endtask

  task automatic test_write_search();
    logic [19:0] r;
    run_cmd(2'b01, 3'd3, 16'hBEEF, r);
    checks++;
    if (r !== {8'd5, 1'b1, 3'd3, 8'h00}) begin
      failures++; $display("FAIL write_beef got=%h want=%h", r, {8'd5, 1'b1, 3'd3, 8'h00});
    end
    run_cmd(2'b00, 3'd0, 16'hBEEF, r);
    checks++;
    if (r !== {8'd5, 1'b1, 3'd3, 8'h08}) begin
      failures++; $display("FAIL search_beef got=%h want=%h", r, {8'd5, 1'b1, 3'd3, 8'h08});
    end
    run_cmd(2'b00, 3'd5, 16'hBEEE, r);
    checks++;
    if (r !== {8'd5, 1'b0, 3'd0, 8'h00}) begin
      failures++; $display("FAIL search_beee got=%h want=%h", r, {8'd5, 1'b0, 3'd0, 8'h00});
    end
    checks++;
    if (entry_valid !== 8'h08) begin
      failures++; $display("FAIL entry_valid_w got=%h want=08", entry_valid);
    end
  endtask

  task automatic test_overwrite();
    logic [19:0] r;
    run_cmd(2'b01, 3'd3, 16'h1234, r);
    checks++;
    if (r !== {8'd9, 1'b1, 3'd3, 8'h00}) begin
      failures++; $display("FAIL overwrite got=%h want=%h", r, {8'd9, 1'b1, 3'd3, 8'h00});
    end
    run_cmd(2'b00, 3'd0, 16'hBEEF, r);
    checks++;
    if (r !== {8'd5, 1'b0, 3'd0, 8'h00}) begin
      failures++; $display("FAIL search_old got=%h want=%h", r, {8'd5, 1'b0, 3'd0, 8'h00});
    end
    run_cmd(2'b00, 3'd0, 16'h1234, r);
    checks++;
    if (r !== {8'd5, 1'b1, 3'd3, 8'h08}) begin
      failures++; $display("FAIL search_new got=%h want=%h", r, {8'd5, 1'b1, 3'd3, 8'h08});
    end
  endtask

  task automatic test_duplicates();
    logic [19:0] r;
    run_cmd(2'b01, 3'd6, 16'h5A5A, r);
    run_cmd(2'b01, 3'd2, 16'h5A5A, r);
    run_cmd(2'b00, 3'd0, 16'h5A5A, r);
    checks++;
    if (r !== {8'd5, 1'b1, 3'd2, 8'h44}) begin
      failures++; $display("FAIL dup_search got=%h want=%h", r, {8'd5, 1'b1, 3'd2, 8'h44});
    end
    run_cmd(2'b10, 3'd2, 16'h0000, r);
    checks++;
    if (r !== {8'd5, 1'b1, 3'd2, 8'h00}) begin
      failures++; $display("FAIL erase_valid got=%h want=%h", r, {8'd5, 1'b1, 3'd2, 8'h00});
    end
    run_cmd(2'b00, 3'd0, 16'h5A5A, r);
    checks++;
    if (r !== {8'd5, 1'b1, 3'd6, 8'h40}) begin
      failures++; $display("FAIL dup_after_erase got=%h want=%h", r, {8'd5, 1'b1, 3'd6, 8'h40});
    end
    run_cmd(2'b10, 3'd2, 16'h0000, r);
    checks++;
    if (r !== {8'd1, 1'b0, 3'd2, 8'h00}) begin
      failures++; $display("FAIL erase_invalid got=%h want=%h", r, {8'd1, 1'b0, 3'd2, 8'h00});
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [19:0] r;
    logic [11:0] held;
    issue(2'b00, 3'd0, 16'h5A5A, lat);
    held = {rsp_hit, rsp_addr, rsp_match_vec};
    checks++;
    if (held !== {1'b1, 3'd6, 8'h40}) begin
      failures++; $display("FAIL bp_rsp got=%h want=%h", held, {1'b1, 3'd6, 8'h40});
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_match_vec} !== {1'b0, 1'b1, held}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=%h want=%h", c,
                 {cmd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_match_vec}, {1'b0, 1'b1, held});
      end
    end
    consume();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL bp_release got=%b want=10", {cmd_ready, rsp_valid});
    end
    run_cmd(2'b11, 3'd5, 16'hFFFF, r);
    checks++;
    if (r !== {8'd1, 1'b0, 3'd5, 8'h00}) begin
      failures++; $display("FAIL reserved got=%h want=%h", r, {8'd1, 1'b0, 3'd5, 8'h00});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [19:0] r;
    while (cmd_ready !== 1'b1) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 3'd1; cmd_key = 16'hCAFE;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, entry_valid} !== '0) begin
      failures++; $display("FAIL mid_reset got=%h want=0", {cmd_ready, rsp_valid, entry_valid});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_init(n);
    checks++;
    if (n !== 64 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reinit got=%0d/%b want=64/0", n, rsp_valid);
    end
    run_cmd(2'b00, 3'd0, 16'hCAFE, r);
    checks++;
    if (r !== {8'd5, 1'b0, 3'd0, 8'h00}) begin
      failures++; $display("FAIL search_cafe got=%h want=%h", r, {8'd5, 1'b0, 3'd0, 8'h00});
    end
    run_cmd(2'b00, 3'd0, 16'h5A5A, r);
    checks++;
    if (r !== {8'd5, 1'b0, 3'd0, 8'h00}) begin
      failures++; $display("FAIL search_stale got=%h want=%h", r, {8'd5, 1'b0, 3'd0, 8'h00});
    end
  endtask

  task automatic test_random();
    logic [KW-1:0] pool [4];
    logic [19:0]   r, e;
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [KW-1:0] k;
    for (int i = 0; i < 4; i++) pool[i] = KW'($urandom);
    for (int t = 0; t < 80; t++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 4) op = 2'b00;
      a  = AW'($urandom);
      k  = ($urandom_range(0, 7) == 0) ? KW'($urandom) : pool[$urandom_range(0, 3)];
      e  = model_rsp(op, a, k);
      run_cmd(op, a, k, r);
      checks++;
      if (r !== e) begin
        failures++; $display("FAIL rand[%0d] op=%0d a=%0d k=%h got=%h want=%h", t, op, a, k, r, e);
      end
      checks++;
      if (entry_valid !== model_valid()) begin
        failures++; $display("FAIL rand_valid[%0d] got=%h want=%h", t, entry_valid, model_valid());
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_search();
    test_overwrite();
    test_duplicates();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
